// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared state encoding and default parameters for the multi-port register file
package regfile_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_DEPTH    = 32;
    localparam int DEF_NRD      = 2;
    localparam int DEF_ZERO_REG = 1;

endpackage

// File: rtl/regfile_mp_if.sv
// rtl/regfile_mp_if.sv - bundle of the register file's control, write and read signals
interface regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2
);
    logic                     clr;
    logic                     busy;
    logic                     write;
    logic [ADDR_W-1:0]        wrAddr;
    logic [DATA_W-1:0]        wrData;
    logic [NRD-1:0]           rd_en;
    logic [NRD*ADDR_W-1:0]    rd_addr;
    logic [NRD*DATA_W-1:0]    rd_data;

    // the agent that issues writes, reads and clears
    modport master (
        output clr, write, wrAddr, wrData, rd_en, rd_addr,
        input  busy, rd_data
    );

    // the register file itself
    modport slave (
        input  clr, write, wrAddr, wrData, rd_en, rd_addr,
        output busy, rd_data
    );
endinterface

// File: rtl/regfile_rdport.sv
// rtl/regfile_rdport.sv - one registered read port with write-first forwarding and zero gating
module regfile_rdport #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clearing,
    input  logic              en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              wr_acc,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;

    // zero during a clear or for the hardwired register, else forward a same-edge write, else the stored entry
    always_comb begin
        data_d = data_q;
        if (en) begin
            if (clearing || ((ZERO_REG != 0) && (addr == '0))) begin
                data_d = '0;
            end else if (wr_acc && (wr_addr == addr)) begin
                data_d = wr_data;
            end else begin
                data_d = mem_data;
            end
        end
    end

    // output register; cleared immediately on reset so stale data never leaks out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign rd_data = data_q;

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-read-port register file with a sequenced hardware clear
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int NRD      = DEF_NRD,
    parameter int ZERO_REG = DEF_ZERO_REG
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    output logic                  busy,
    input  logic                  write,
    input  logic [ADDR_W-1:0]     wrAddr,
    input  logic [DATA_W-1:0]     wrData,
    input  logic [NRD-1:0]        rd_en,
    input  logic [NRD*ADDR_W-1:0] rd_addr,
    output logic [NRD*DATA_W-1:0] rd_data
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    state_e            state_q;
    state_e            state_d;
    logic [ADDR_W-1:0] clr_cnt_q;
    logic [ADDR_W-1:0] clr_cnt_d;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    logic              wr_acc;
    logic              clearing;

    // clear walks every entry once, then waits in READY for the next clr pulse
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            CLEAR: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == LAST_IDX) begin
                    state_d = READY;
                end
            end
            READY: begin
                if (clr) begin
                    state_d   = CLEAR;
                    clr_cnt_d = '0;
                end
            end
            default: begin
                state_d   = CLEAR;
                clr_cnt_d = '0;
            end
        endcase
    end

    // state and clear counter; reset restarts the clear from entry 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    assign clearing = (state_q == CLEAR);
    assign busy     = clearing;

    // single array write port: the clear sequence owns it, otherwise accepted user writes
    always_comb begin
        wr_acc = (state_q == READY) && !clr && write &&
                 !((ZERO_REG != 0) && (wrAddr == '0));
        if (clearing) begin
            mem_we    = 1'b1;
            mem_waddr = clr_cnt_q;
            mem_wdata = '0;
        end else begin
            mem_we    = wr_acc;
            mem_waddr = wrAddr;
            mem_wdata = wrData;
        end
    end

    // storage array is not reset; the clear sequence initialises it
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        assign addr = rd_addr[p*ADDR_W +: ADDR_W];

        regfile_rdport #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG)
        ) u_rdport (
            .clk      (clk),
            .rst_n    (rst_n),
            .clearing (clearing),
            .en       (rd_en[p]),
            .addr     (addr),
            .mem_data (mem_q[addr]),
            .wr_acc   (wr_acc),
            .wr_addr  (wrAddr),
            .wr_data  (wrData),
            .rd_data  (rd_data[p*DATA_W +: DATA_W])
        );
    end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, meaning register width in bits.
REQ-002 SHALL provide parameter DEPTH, default 32, meaning number of registers; a power of two, at least 2.
REQ-003 SHALL provide parameter ADDR_W, default $clog2(DEPTH), meaning address width.
REQ-004 SHALL provide parameter NRD, default 2, meaning number of read ports, 1..4.
REQ-005 SHALL provide parameter ZERO_REG, default 1, meaning 1 makes address 0 hardwired to zero.
REQ-006 SHALL have one clock and an asynchronous, active-low reset, with ports as follows: clk, input, 1, rising-edge clock.
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port clr, input, 1, one-cycle pulse requesting a full clear.
REQ-009 SHALL have port busy, output, 1, high while a clear sequence runs.
REQ-010 SHALL have port write, input, 1, write enable.
REQ-011 SHALL have port wrAddr, input, ADDR_W, write address.
REQ-012 SHALL have port wrData, input, DATA_W, write data.
REQ-013 SHALL have port rd_en, input, NRD, per-port read enable.
REQ-014 SHALL have port rd_addr, input, NRD*ADDR_W, packed read addresses, with port p at bits [p*ADDR_W +: ADDR_W].
REQ-015 SHALL have port rd_data, output, NRD*DATA_W, packed registered read data, with port p at bits [p*DATA_W +: DATA_W].

Function
REQ-016 SHALL implement a two-state FSM with states CLEAR and READY, plus a clear counter clr_cnt of ADDR_W bits.
REQ-017 SHALL, in CLEAR, write 0 to entry clr_cnt every cycle and increment clr_cnt; when clr_cnt==DEPTH-1 it SHALL move to READY on that edge, so a clear lasts exactly DEPTH cycles.
REQ-018 SHALL, in READY, move to CLEAR with clr_cnt=0 on the edge where clr=1; clr while in CLEAR SHALL be ignored and SHALL NOT restart the count.
REQ-019 SHALL drive busy=1 exactly when the state is CLEAR.
REQ-020 SHALL perform a write when write=1 in READY, setting entry wrAddr to wrData at the rising edge, except that it SHALL NOT write when ZERO_REG=1 and wrAddr==0.
REQ-021 SHALL silently drop a write presented in CLEAR or in the same cycle as an accepted clr; clear wins.
REQ-022 SHALL, for each port p with rd_en[p]=1, update rd_data[p] at the edge, with one cycle of latency, to the entry at rd_addr[p].
REQ-023 SHALL hold rd_data[p] unchanged when rd_en[p]=0.
REQ-024 SHALL use write-first forwarding: if an accepted write targets rd_addr[p] at the same edge, rd_data[p] SHALL take wrData rather than the old entry.
REQ-025 SHALL return 0 for any read when ZERO_REG=1 and rd_addr[p]==0, regardless of forwarding.
REQ-026 SHALL return 0 on every enabled port for reads issued in CLEAR, including the edge at which CLEAR ends.
REQ-027 SHALL allow all NRD ports to read the same address simultaneously, each receiving identical data.
REQ-028 SHALL treat the DEPTH-1 entry and the clr_cnt wrap as ordinary cases, with no extra cycle and no out-of-range access.

Reset
REQ-029 SHALL, on assertion of rst_n=0, immediately force state=CLEAR, clr_cnt=0, rd_data=all zeros, and busy=1.
REQ-030 SHALL NOT asynchronously reset array contents; it SHALL instead clear them through the CLEAR sequence after rst_n deasserts, so busy falls DEPTH cycles after the first post-reset edge.
REQ-031 SHALL restart a clear from clr_cnt=0 if reset asserts mid-clear or mid-operation, and SHALL treat any contents written before reset as lost.

Structure
REQ-032 SHALL place the FSM state encoding (CLEAR, READY) and the default parameter constants in the shared package regfile_pkg.
REQ-033 SHALL use a single sub-module regfile_rdport, instantiated NRD times via generate, containing the per-port address compare, forwarding mux, zero-gating and output register; the array, FSM and write logic SHALL stay in regfile_mp.
REQ-034 SHALL be fully synchronous except for the rst_n-driven flops, with no combinational path from inputs to rd_data.

Verification
REQ-035 The bench SHALL cover reset and clear: pulse rst_n low, then run 32 clocks -> busy=1 for exactly 32 edges, and all reads of addresses 0..31 return 0x00000000.
REQ-036 The bench SHALL cover basic write/read: write 0xDEADBEEF to address 5, then read port 0 at address 5 the next cycle -> rd_data[0]=0xDEADBEEF one cycle later.
REQ-037 The bench SHALL cover forwarding: write 0x12345678 to address 7 while ports 0 and 1 both read address 7 in the same cycle -> both ports show 0x12345678 after one edge, and neither shows stale data.
REQ-038 The bench SHALL cover the zero register: write 0xFFFFFFFF to address 0 while reading address 0 in the same cycle -> rd_data=0, and a later read of address 0 also gives 0; with ZERO_REG=0 the same sequence returns 0xFFFFFFFF.
REQ-039 The bench SHALL cover clear priority: assert clr together with a write of 0xA5A5A5A5 to address 3 -> busy rises, and after the clear completes a read of address 3 returns 0; a write issued mid-clear is dropped.
REQ-040 The bench SHALL cover hold and reset mid-clear: with rd_en[1]=0, change rd_addr[1] -> rd_data[1] is unchanged; then assert rst_n=0 at clr_cnt=10 -> rd_data is zero immediately, and busy lasts a full DEPTH cycles after release.
